// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA joystick scanner: scan FSM states,
// select-width helper and the active-low "released" level.
package jamma_pkg;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_SAMPLE = 1'b1
  } scan_state_e;

  // Joystick lines are active low, so an idle/released bit reads as 1.
  localparam logic JOY_RELEASED = 1'b1;

  localparam int SETTLE_CNT_W = 8;
  localparam int DEB_CNT_W    = 4;

  function automatic int sel_width(input int num_players);
    return (num_players <= 1) ? 1 : $clog2(num_players);
  endfunction

endpackage

// File: rtl/jamma_joy_scan_if.sv
// Bus bundle between the joystick scanner and its surroundings: shared external
// bus, onboard joystick, select index and debounced player states.
interface jamma_joy_scan_if
  import jamma_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int JOY_W       = 8
);

  localparam int SEL_W = sel_width(NUM_PLAYERS);

  logic [JOY_W-1:0]             jjoy;
  logic [JOY_W-1:0]             onboard_joy;
  logic [SEL_W-1:0]             jselect;
  logic [NUM_PLAYERS*JOY_W-1:0] joy_out;
  logic                         scan_done;

  modport master (
    output jjoy,
    output onboard_joy,
    input  jselect,
    input  joy_out,
    input  scan_done
  );

  modport slave (
    input  jjoy,
    input  onboard_joy,
    output jselect,
    output joy_out,
    output scan_done
  );

endinterface

// File: rtl/jamma_debounce.sv
// Per-player debouncer: each bit follows its sample only after DEBOUNCE
// consecutive differing samples, counted on sample_en edges only.
module jamma_debounce
  import jamma_pkg::*;
#(
  parameter int JOY_W    = 8,
  parameter int DEBOUNCE = 1
) (
  input  logic             clk12,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [JOY_W-1:0] sample_i,
  output logic [JOY_W-1:0] joy_o
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE - 1);

  logic [JOY_W-1:0]                out_q, out_d;
  logic [JOY_W-1:0][DEB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (sample_en) begin
      for (int b = 0; b < JOY_W; b++) begin
        if (sample_i[b] == out_q[b]) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] == CNT_LAST) begin
          out_d[b] = sample_i[b];
          cnt_d[b] = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + DEB_CNT_W'(1);
        end
      end
    end
  end

  // Counters reset too, so a reset mid-debounce discards any partial run.
  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      out_q <= {JOY_W{JOY_RELEASED}};
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign joy_o = out_q;

endmodule

// File: rtl/jamma_joy_scan.sv
// JAMMA joystick scanner: time-multiplexes a shared active-low bus across
// players with a SETTLE/SAMPLE FSM and debounces each player's bits.
module jamma_joy_scan
  import jamma_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int JOY_W         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int DEBOUNCE      = 1,
  parameter int SPLIT_EN      = 1
) (
  input  logic             clk12,
  input  logic             reset,
  jamma_joy_scan_if.slave  bus
);

  localparam int SEL_W = sel_width(NUM_PLAYERS);
  localparam bit SINGLE = (SPLIT_EN == 0) || (NUM_PLAYERS == 1);
  // In direct mode the last scanned player is 0, which pins sel at 0.
  localparam logic [SEL_W-1:0] LAST_SEL = SINGLE ? '0 : SEL_W'(NUM_PLAYERS - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  scan_state_e             state_q, state_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    scan_done_q, scan_done_d;
  logic                    sample_fire;

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= '0;
      sel_q        <= '0;
      scan_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      sel_q        <= sel_d;
      scan_done_q  <= scan_done_d;
    end
  end

  // NOTE: every output of a comb block gets a default first, so no path latches.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    sel_d        = sel_q;
    unique case (state_q)
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        state_d      = ST_SETTLE;
        settle_cnt_d = '0;
        sel_d        = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_comb begin
    sample_fire = (state_q == ST_SAMPLE);
    scan_done_d = sample_fire && (sel_q == LAST_SEL);
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [JOY_W-1:0] sample;
    logic             sample_en;

    // The onboard joystick is wired-AND into player 0 only.
    if (p == 0) begin : g_merge
      assign sample = bus.jjoy & bus.onboard_joy;
    end else begin : g_plain
      assign sample = bus.jjoy;
    end

    assign sample_en = sample_fire && (sel_q == SEL_W'(p));

    jamma_debounce #(
      .JOY_W    (JOY_W),
      .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
      .clk12     (clk12),
      .reset     (reset),
      .sample_en (sample_en),
      .sample_i  (sample),
      .joy_o     (bus.joy_out[p*JOY_W +: JOY_W])
    );
  end

  assign bus.jselect   = sel_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: doc/jamma_joy_scan.md
JAMMA_JOY_SCAN -- requirements
Module: jamma_joy_scan

Interface
REQ-001 The block SHALL have parameter NUM_PLAYERS, default 2, giving the number of time-multiplexed player ports on the shared bus (1..4).
REQ-002 The block SHALL have parameter JOY_W, default 8, giving the bits per player (up, down, left, right, fire1, fire2, fire3, start).
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the wait cycles after a select change before sampling (1..255).
REQ-004 The block SHALL have parameter DEBOUNCE, default 1, giving the consecutive equal samples needed to change an output bit (1..15; 1 disables debouncing).
REQ-005 The block SHALL have parameter SPLIT_EN, default 1, where 0 means single-player direct mode and the select output is held at 0.
REQ-006 Port clk12, input, 1 bit: the sole clock.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port jjoy, input, JOY_W bits: the shared external joystick bus, active low.
REQ-009 Port onboard_joy, input, JOY_W bits: the local joystick, active low, merged into player 0 only.
REQ-010 Port jselect, output, SEL_W = max(1, clog2(NUM_PLAYERS)) bits: the external bus select index.
REQ-011 Port joy_out, output, NUM_PLAYERS*JOY_W bits: debounced, active-low player states, with player p at bits [p*JOY_W +: JOY_W].
REQ-012 Port scan_done, output, 1 bit: a one-cycle pulse after each complete scan.

Function
REQ-013 The scan FSM SHALL have exactly two states: SETTLE (a counter counts 0..SETTLE_CYCLES-1) and SAMPLE (a single cycle).
REQ-014 On the clk12 edge ending SAMPLE, the block SHALL capture jjoy for player index sel, advance sel, and return to SETTLE with the counter at 0.
REQ-015 SEL SHALL advance as sel+1, wrapping from NUM_PLAYERS-1 to 0; values at or above NUM_PLAYERS SHALL never appear on jselect (non-power-of-two counts included).
REQ-016 jselect SHALL be a registered copy of sel, so it is stable for all SETTLE_CYCLES+1 cycles of a slot.
REQ-017 The per-player slot period SHALL be SETTLE_CYCLES+1 cycles, and the full scan period SHALL be NUM_PLAYERS*(SETTLE_CYCLES+1) cycles.
REQ-018 The sample for player 0 SHALL be jjoy AND onboard_joy (bitwise, active low); all other players SHALL take jjoy unmodified.
REQ-019 When SPLIT_EN=0 or NUM_PLAYERS=1, jselect SHALL be 0 and only player 0 SHALL be sampled, once per SETTLE_CYCLES+1 cycles.
REQ-020 Debounce: each player bit SHALL have its own counter that counts consecutive samples differing from the current output and clears on any sample equal to the output.
REQ-021 An output bit SHALL take the sampled value on the edge completing the DEBOUNCE-th consecutive differing sample, then its counter SHALL clear.
REQ-022 With DEBOUNCE=1, joy_out SHALL update on the same edge that captures the sample (zero extra latency).
REQ-023 Debounce counters SHALL advance only on their own player's SAMPLE edge, so debounce time is DEBOUNCE scan periods.
REQ-024 scan_done SHALL be high for exactly the one cycle following the SAMPLE edge of player NUM_PLAYERS-1.
REQ-025 Counter widths SHALL be 8 bits for settle and 4 bits per debouncer; no counter SHALL wrap beyond its parameter limit.

Reset
REQ-026 While reset is high, asynchronously: state=SETTLE, settle counter=0, sel=0, jselect=0, joy_out all ones (released), all debounce counters=0, scan_done=0.
REQ-027 On reset deassertion, the first SAMPLE SHALL occur SETTLE_CYCLES cycles later, for player 0.
REQ-028 Reset asserted mid-slot or mid-debounce SHALL discard the partial count with no output glitch to 0.

Structure
REQ-029 Package jamma_pkg SHALL hold the FSM state enum, the SEL_W width function, and the active-low "released" constant.
REQ-030 One sub-module, jamma_debounce (one player, JOY_W bits, DEBOUNCE parameter, sample-enable input), SHALL be instantiated NUM_PLAYERS times.

Verification
REQ-031 Defaults with jjoy=8'hFF and onboard=8'hFF after reset: jselect toggles every 2 cycles, scan_done pulses every 4 cycles, joy_out=16'hFFFF.
REQ-032 Defaults, drive jjoy=8'hFE only while jselect=1: the following sample edge gives joy_out[15:8]=8'hFE and joy_out[7:0]=8'hFF.
REQ-033 Defaults, onboard_joy=8'h7F and jjoy=8'hFF: joy_out[7:0]=8'h7F and joy_out[15:8]=8'hFF.
REQ-034 NUM_PLAYERS=3, SETTLE_CYCLES=2: jselect follows 0,1,2,0 with 3 cycles each, and scan_done has a period of 9 cycles.
REQ-035 DEBOUNCE=3, with bit 0 for player 0 pulsed low for 2 scans then held low: output stays 1 through the pulse and goes 0 on the 3rd consecutive low sample.
REQ-036 Reset pulsed for 1 cycle mid-slot with joy_out=16'h00FF: outputs immediately become all ones, jselect=0, and the first sample follows SETTLE_CYCLES cycles later.
